pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register for the MIPS pipeline; the generalised successor to the fixed-width IF/ID latch. It carries a DATA_W-bit payload between two pipeline stages using a valid/ready handshake. A two-entry skid buffer sustains full throughput under back-pressure. It adds an external hold, a flush that turns held words into bubbles while keeping masked fields (e.g. PC+4), and a saturating stall counter for performance monitoring. One instance is used per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- DATA_W, 64: payload width (IF/ID: {instruction[63:32], PC4[31:0]}).
- FLUSH_KEEP_MASK, 64'h0000_0000_FFFF_FFFF: payload bits retained on flush; all other bits are zeroed. Width is DATA_W.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- in_valid  in  1  upstream word present.
- in_ready  out  1  stage can accept a word this cycle.
- in_data  in  DATA_W  upstream payload.
- hold  in  1  external stall (hazard unit); freezes the stage.
- flush  in  1  synchronous flush (branch/jump taken).
- out_valid  out  1  word presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload of the head entry.
- out_bubble  out  1  head entry is a flushed bubble.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- Storage: head register H (drives outputs) and skid register S; each has valid and bubble flags.
- Occupancy states: EMPTY (H and S invalid), ONE (H valid), FULL (H and S valid). S is never valid while H is invalid.
- acc = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !S.valid & !hold. It is combinational only from registered state and hold.
- out_valid = H.valid & !hold; out_data = H.data; out_bubble = H.bubble & H.valid.
- Transitions:
  - EMPTY: acc -> ONE.
  - ONE: acc & !pop -> FULL (word goes to S); acc & pop -> ONE (H replaced); pop & !acc -> EMPTY.
  - FULL: pop -> ONE (S moves to H, S cleared); no acc is possible in FULL.
- hold=1: no acc, no pop, contents unchanged. Flush still applies.
- flush=1 (same edge as any transfer): every entry valid after the edge, including a word accepted that cycle, gets data &= FLUSH_KEEP_MASK and bubble=1. Occupancy follows the normal rules.
- flush with EMPTY and no acc: no effect.
- Bubbles are ordinary entries downstream. They are consumed by pop like any other word.
- stall_cnt increments by 1 on each edge where H.valid & (hold | !out_ready). It saturates at 2^CNT_W-1 and only reset clears it.
- Reset: H, S invalid; H.data = 0, S.data = 0; bubble flags 0; stall_cnt = 0.
  - Outputs during and after reset: out_valid=0, out_data=0, out_bubble=0, stall_cnt=0, in_ready=!hold.

## Timing
- Latency 1 cycle: a word accepted at edge n appears on out_data after edge n.
- Throughput 1 word/cycle with out_ready held high; no bubble is inserted by the stage itself.
- After out_ready falls, at most one further word is accepted (into S). in_ready drops in the cycle after that acceptance.
- Reset is asynchronous assert and is sampled as released at the first edge with reset=1. A mid-transfer reset discards H and S with no partial state.
- No combinational path from out_ready to in_ready.

## Test plan
- Reset: drive reset=0 mid-stream with FULL state -> out_valid=0, out_data=0, stall_cnt=0, in_ready=1 immediately. After release, the first word 0x2402_0005_0000_0004 appears 1 cycle after acceptance.
- Streaming: 8 back-to-back words with out_ready=1 -> out_data sequence identical, one per cycle, latency 1, in_ready constantly 1.
- Back-pressure: out_ready=0 for 3 cycles while streaming -> one extra word enters S, in_ready=0, stall_cnt=3. With out_ready=1, words exit in order with no loss or duplication.
- Flush: FULL with H=0x8C41_0010_0000_0020, S=0x1000_0003_0000_0024, flush=1 -> H=0x0000_0000_0000_0020 with out_bubble=1, S=0x0000_0000_0000_0024 with bubble=1.
- Flush and accept in the same cycle: in ONE with pop, flush=1, in_data=0xAC22_0000_0000_0028 -> H=0x0000_0000_0000_0028, out_bubble=1.
- Hold and saturation: hold=1 with H valid -> out_valid=0, in_ready=0, data frozen. With CNT_W=4, holding 20 cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with a two-entry skid
// buffer. It supports an external hold, and a flush that turns held words
// into bubbles while keeping the masked payload fields. A saturating stall
// counter is included for performance monitoring.
module pipe_stage_reg #(
    parameter int                DATA_W          = 64,
    parameter logic [DATA_W-1:0] FLUSH_KEEP_MASK = DATA_W'(64'h0000_0000_FFFF_FFFF),
    parameter int                CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bubble,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Occupancy of the head (H) and skid (S) entries. S is only ever valid
    // when H is valid, so three states cover every legal combination.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t              state, state_nxt;
    logic [DATA_W-1:0] h_data, h_data_nxt;
    logic [DATA_W-1:0] s_data, s_data_nxt;
    logic              h_bubble, h_bubble_nxt;
    logic              s_bubble, s_bubble_nxt;
    logic              h_valid, s_valid;
    logic              acc, pop;

    assign h_valid = (state != EMPTY);
    assign s_valid = (state == FULL);

    // in_ready depends only on registered state and hold. This keeps
    // out_ready off the upstream timing path.
    assign in_ready   = !s_valid && !hold;
    assign out_valid  = h_valid && !hold;
    assign out_data   = h_data;
    assign out_bubble = h_bubble && h_valid;

    assign acc = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    // Next occupancy and entry contents, followed by flush masking of every entry that is valid after the edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        state_nxt    = state;
        h_data_nxt   = h_data;
        h_bubble_nxt = h_bubble;
        s_data_nxt   = s_data;
        s_bubble_nxt = s_bubble;

        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt    = ONE;
                    h_data_nxt   = in_data;
                    h_bubble_nxt = 1'b0;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    h_data_nxt   = in_data;
                    h_bubble_nxt = 1'b0;
                end else if (acc) begin
                    state_nxt    = FULL;
                    s_data_nxt   = in_data;
                    s_bubble_nxt = 1'b0;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // No accept is possible here because in_ready is low.
                if (pop) begin
                    state_nxt    = ONE;
                    h_data_nxt   = s_data;
                    h_bubble_nxt = s_bubble;
                    s_data_nxt   = '0;
                    s_bubble_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase

        // A flush also covers any word accepted on the same edge.
        if (flush) begin
            if (state_nxt != EMPTY) begin
                h_data_nxt   = h_data_nxt & FLUSH_KEEP_MASK;
                h_bubble_nxt = 1'b1;
            end
            if (state_nxt == FULL) begin
                s_data_nxt   = s_data_nxt & FLUSH_KEEP_MASK;
                s_bubble_nxt = 1'b1;
            end
        end
    end

    // State and entry registers. An asynchronous reset discards both entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            h_data   <= '0;
            h_bubble <= 1'b0;
            s_data   <= '0;
            s_bubble <= 1'b0;
        end else begin
            // NOTE: use non-blocking assignments so that every register samples pre-edge values, whatever the statement order.
            state    <= state_nxt;
            h_data   <= h_data_nxt;
            h_bubble <= h_bubble_nxt;
            s_data   <= s_data_nxt;
            s_bubble <= s_bubble_nxt;
        end
    end

    // Stall counter: counts cycles in which the head word is held or back-pressured. It saturates at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (h_valid && (hold || !out_ready) && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed tests for pipe_stage_reg. Expected values are
// worked out by hand. A second instance with CNT_W=4 shares the same inputs
// and exercises stall-counter saturation.
module tb_pipe_stage_reg;

    localparam int DATA_W = 64;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              hold;
    logic              flush;
    logic              out_ready;

    logic              in_ready, out_valid, out_bubble;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       stall_cnt;

    logic              s_in_ready, s_out_valid, s_out_bubble;
    logic [DATA_W-1:0] s_out_data;
    logic [3:0]        s_stall_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    pipe_stage_reg dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .hold       (hold),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bubble (out_bubble),
        .stall_cnt  (stall_cnt)
    );

    pipe_stage_reg #(.CNT_W(4)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_data    (in_data),
        .hold       (hold),
        .flush      (flush),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_data   (s_out_data),
        .out_bubble (s_out_bubble),
        .stall_cnt  (s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] w;
        w = 64'h2402_0005_0000_0004;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; hold = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2;
        n_asserts++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_asserts++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_asserts++; if (out_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_out_bubble: got %b want 0", out_bubble); end
        n_asserts++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        hold = 1'b1; #1;
        n_asserts++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_hold: got %b want 0", in_ready); end
        hold = 1'b0;
        // Release reset, then fill the stage to FULL while downstream is stalled.
        tick();
        reset = 1'b1;
        in_valid = 1'b1; in_data = 64'h1111_0000_0000_0008;
        tick();
        in_data = 64'h2222_0000_0000_000C;
        tick();
        in_valid = 1'b0;
        n_asserts++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        n_asserts++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL full_stall_cnt: got %0d want 1", stall_cnt); end
        // Assert reset asynchronously in the middle of the cycle.
        #2; reset = 1'b0; #1;
        n_asserts++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        n_asserts++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL midreset_out_data: got %h want 0", out_data); end
        n_asserts++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL midreset_stall_cnt: got %0d want 0", stall_cnt); end
        n_asserts++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        // Release reset before the next edge and present the first word.
        reset = 1'b1; in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        #1;
        n_asserts++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_word_early: got out_valid %b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        n_asserts++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_word_valid: got %b want 1", out_valid); end
        n_asserts++; if (out_data !== w) begin n_fail++; $display("FAIL first_word_data: got %h want %h", out_data, w); end
        tick();
        n_asserts++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_word_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [DATA_W-1:0] w;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = {32'h2000_0000 + 32'(i), 32'h0000_0100 + 32'(4 * i)};
            in_valid = 1'b1; in_data = w;
            #1;
            n_asserts++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            n_asserts++; if (out_valid !== 1'b1 || out_data !== w) begin n_fail++; $display("FAIL stream_out[%0d]: got v=%b %h want v=1 %h", i, out_valid, out_data, w); end
        end
        in_valid = 1'b0;
        tick();
        n_asserts++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b want 0", out_valid); end
        n_asserts++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_back_pressure();
        logic [DATA_W-1:0] bw [4];
        int si, ri;
        bw[0] = 64'h3000_0000_0000_0200;
        bw[1] = 64'h3000_0001_0000_0204;
        bw[2] = 64'h3000_0002_0000_0208;
        bw[3] = 64'h3000_0003_0000_020C;
        si = 0; ri = 0;
        for (int c = 0; c < 10; c++) begin
            out_ready = !(c >= 1 && c <= 3);
            if (si < 4) begin in_valid = 1'b1; in_data = bw[si]; end
            else begin in_valid = 1'b0; in_data = '0; end
            #1;
            if (c == 1) begin
                n_asserts++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_skid_accept: got in_ready %b want 1", in_ready); end
            end
            if (c == 2 || c == 3) begin
                n_asserts++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
            end
            if (c == 4) begin
                n_asserts++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d want 3", stall_cnt); end
            end
            if (out_valid && out_ready) begin
                n_asserts++;
                if (ri >= 4) begin n_fail++; $display("FAIL bp_extra_word: got %h want none", out_data); end
                else if (out_data !== bw[ri]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", ri, out_data, bw[ri]); end
                ri++;
            end
            if (in_valid && in_ready) si++;
            tick();
        end
        n_asserts++; if (ri !== 4) begin n_fail++; $display("FAIL bp_count: got %0d words want 4", ri); end
        n_asserts++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_stall_final: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h8C41_0010_0000_0020;
        tick();
        in_data = 64'h1000_0003_0000_0024;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_asserts++; if (out_valid !== 1'b1 || out_data !== 64'h0000_0000_0000_0020) begin n_fail++; $display("FAIL flush_head: got v=%b %h want v=1 0000000000000020", out_valid, out_data); end
        n_asserts++; if (out_bubble !== 1'b1) begin n_fail++; $display("FAIL flush_head_bubble: got %b want 1", out_bubble); end
        n_asserts++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_still_full: got in_ready %b want 0", in_ready); end
        out_ready = 1'b1;
        tick();
        n_asserts++; if (out_data !== 64'h0000_0000_0000_0024 || out_bubble !== 1'b1) begin n_fail++; $display("FAIL flush_skid: got %h b=%b want 0000000000000024 b=1", out_data, out_bubble); end
        tick();
        n_asserts++; if (out_valid !== 1'b0 || out_bubble !== 1'b0) begin n_fail++; $display("FAIL flush_drain: got v=%b b=%b want 0 0", out_valid, out_bubble); end
    endtask

    task automatic test_flush_accept();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'h1234_5678_0000_002C;
        tick();
        in_data = 64'hAC22_0000_0000_0028; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        n_asserts++; if (out_valid !== 1'b1 || out_data !== 64'h0000_0000_0000_0028) begin n_fail++; $display("FAIL flush_acc_data: got v=%b %h want v=1 0000000000000028", out_valid, out_data); end
        n_asserts++; if (out_bubble !== 1'b1) begin n_fail++; $display("FAIL flush_acc_bubble: got %b want 1", out_bubble); end
        tick();
        // A flush while EMPTY with no accept must leave the stage empty.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_asserts++; if (out_valid !== 1'b0 || out_bubble !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got v=%b b=%b want 0 0", out_valid, out_bubble); end
        in_valid = 1'b1; in_data = 64'h5555_AAAA_0000_0030;
        tick();
        in_valid = 1'b0;
        n_asserts++; if (out_data !== 64'h5555_AAAA_0000_0030 || out_bubble !== 1'b0) begin n_fail++; $display("FAIL post_flush_word: got %h b=%b want 5555aaaa00000030 b=0", out_data, out_bubble); end
        tick();
    endtask

    task automatic test_hold_saturation();
        logic [DATA_W-1:0] z, z2;
        z  = 64'h0123_4567_0000_003C;
        z2 = 64'hDEAD_BEEF_0000_0040;
        #1; reset = 1'b0; #1; reset = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = z;
        tick();
        in_data = z2; hold = 1'b1;
        #1;
        n_asserts++; if (out_valid !== 1'b0 || s_out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_out_valid: got %b/%b want 0/0", out_valid, s_out_valid); end
        n_asserts++; if (in_ready !== 1'b0 || s_in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %b/%b want 0/0", in_ready, s_in_ready); end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 5) begin
                n_asserts++; if (stall_cnt !== 16'd5 || s_stall_cnt !== 4'd5) begin n_fail++; $display("FAIL hold_cnt5: got %0d/%0d want 5/5", stall_cnt, s_stall_cnt); end
            end
        end
        n_asserts++; if (stall_cnt !== 16'd20) begin n_fail++; $display("FAIL hold_cnt20: got %0d want 20", stall_cnt); end
        n_asserts++; if (s_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL hold_saturate: got %0d want 15", s_stall_cnt); end
        n_asserts++; if (out_data !== z || s_out_data !== z) begin n_fail++; $display("FAIL hold_frozen: got %h/%h want %h", out_data, s_out_data, z); end
        hold = 1'b0;
        #1;
        n_asserts++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: got v=%b r=%b want 1 1", out_valid, in_ready); end
        tick();
        in_valid = 1'b0;
        n_asserts++; if (out_data !== z2) begin n_fail++; $display("FAIL hold_next_word: got %h want %h", out_data, z2); end
        // A flush still applies while the stage is held.
        hold = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_asserts++; if (out_data !== 64'h0000_0000_0000_0040 || out_bubble !== 1'b1 || s_out_bubble !== 1'b1) begin n_fail++; $display("FAIL hold_flush: got %h b=%b/%b want 0000000000000040 b=1/1", out_data, out_bubble, s_out_bubble); end
        n_asserts++; if (s_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL hold_sat_stays: got %0d want 15", s_stall_cnt); end
        hold = 1'b0;
        tick();
        n_asserts++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drain: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_flush_accept();
        test_hold_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
